// File: rtl/store_direct.sv
// ---------------------------------------------------------------------------
// store_direct
//
// Executes a single "store register to memory" operation. A request carries
// a destination address (Ro) and a source value (Rs). Both are captured on
// accept, then presented to the memory with a write strobe until the memory
// acknowledges or a wait budget runs out. Requests that target an address
// above MEM_TOP are rejected without ever touching the memory.
//
// Parameters
//   AW       address width
//   DW       data width
//   MEM_TOP  highest legal store address
//   TIMEOUT  maximum number of extra WRITE cycles without mem_ack (1..255)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   st_valid   store request valid
//   st_ready   block idle and able to accept a request
//   Ro         destination address of the store
//   Rs         value to be stored
//   mem_addr   memory write address (0 when mem_we is low)
//   mem_wdata  memory write data    (0 when mem_we is low)
//   mem_we     memory write strobe
//   mem_ack    memory write acknowledge (only looked at in WRITE)
//   done       one-cycle pulse, store completed
//   err        one-cycle pulse, store rejected or timed out
//   busy       high whenever the block is not idle
// ---------------------------------------------------------------------------
module store_direct #(
  parameter int            AW      = 20,
  parameter int            DW      = 20,
  parameter logic [AW-1:0] MEM_TOP = AW'(20'hFFFFF),
  parameter int            TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] Ro,
  input  logic [DW-1:0] Rs,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic          mem_ack,
  output logic          done,
  output logic          err,
  output logic          busy
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  // Wait counter is 8 bits wide so it covers the whole legal TIMEOUT range.
  localparam int         CW        = 8;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] data_q,  data_d;

  logic accept;
  logic addr_legal;

  assign accept     = st_valid && (state_q == ST_IDLE);
  // Range check is done on the incoming address in the accept cycle; that is
  // exactly the value being latched, so it is equivalent to checking the
  // latched copy one cycle later but saves a cycle of latency.
  assign addr_legal = (Ro <= MEM_TOP);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold it.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = Ro;
          data_d = Rs;
          cnt_d  = '0;
          state_d = addr_legal ? ST_WRITE : ST_ERR;
        end
      end

      ST_WRITE: begin
        // Ack is checked first so an ack arriving on the last allowed cycle
        // still completes the store instead of timing out.
        if (mem_ack) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential update
  // -------------------------------------------------------------------------
  // NOTE: the latched address/data are reset along with the control state so
  // nothing stale can reach the memory port after a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its input from before the clock edge.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // All outputs decode the registered state only, so an asynchronous reset
  // drives them to their idle values immediately, and done/err are mutually
  // exclusive by construction.
  always_comb begin
    st_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    mem_we    = (state_q == ST_WRITE);
    done      = (state_q == ST_DONE);
    err       = (state_q == ST_ERR);
    // Address and data buses are gated to zero outside the write strobe.
    mem_addr  = mem_we ? addr_q : '0;
    mem_wdata = mem_we ? data_q : '0;
  end

endmodule

// File: tb/tb_store_direct.sv
// ---------------------------------------------------------------------------
// tb_store_direct
//
// Directed bench for store_direct. Instantiated with MEM_TOP = 20'h0FFFF and
// TIMEOUT = 15. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_store_direct;

  localparam int AW = 20;
  localparam int DW = 20;

  logic          clk;
  logic          rst_n;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] Ro;
  logic [DW-1:0] Rs;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_ack;
  logic          done;
  logic          err;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  store_direct #(
    .AW     (AW),
    .DW     (DW),
    .MEM_TOP(20'h0FFFF),
    .TIMEOUT(15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .Ro       (Ro),
    .Rs       (Rs),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_ack  (mem_ack),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a request on one falling edge and withdraws it on the next; the
  // caller ends up at the falling edge right after the accepting rising edge.
  task automatic do_accept(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    st_valid = 1'b1;
    Ro       = a;
    Rs       = d;
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  // Control outputs packed as {st_ready, busy, mem_we, done, err}.
  task automatic test_reset;
    rst_n = 1'b0; st_valid = 1'b0; mem_ack = 1'b0; Ro = '0; Rs = '0;
    #12;
    n_checks++;
    if ({st_ready, busy, mem_we, done, err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 10000", {st_ready, busy, mem_we, done, err});
    end
    n_checks++;
    if ({mem_addr, mem_wdata} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h data %h want 0/0", mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_store;
    do_accept(20'h00010, 20'hABCDE);
    // first WRITE cycle
    n_checks++;
    if ({st_ready, busy, mem_we, done, err} !== 5'b01100 ||
        mem_addr !== 20'h00010 || mem_wdata !== 20'hABCDE) begin
      n_fail++;
      $display("FAIL basic_w1: ctrl %b addr %h data %h want 01100/00010/abcde",
               {st_ready, busy, mem_we, done, err}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    // second WRITE cycle, memory acknowledges
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 20'h00010 || mem_wdata !== 20'hABCDE) begin
      n_fail++;
      $display("FAIL basic_w2: we %b addr %h data %h want 1/00010/abcde",
               mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if ({st_ready, busy, mem_we, done, err} !== 5'b01010 ||
        {mem_addr, mem_wdata} !== 40'h0) begin
      n_fail++;
      $display("FAIL basic_done: ctrl %b addr %h data %h want 01010/0/0",
               {st_ready, busy, mem_we, done, err}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    n_checks++;
    if ({st_ready, busy, mem_we, done, err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL basic_idle: got %b want 10000", {st_ready, busy, mem_we, done, err});
    end
  endtask

  task automatic test_ack_ignored_idle;
    mem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({st_ready, busy, mem_we, done, err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL idle_ack: got %b want 10000", {st_ready, busy, mem_we, done, err});
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout;
    int  we_cycles;
    bit  saw_done;
    we_cycles = 0;
    saw_done  = 1'b0;
    do_accept(20'h00020, 20'h11111);
    for (int i = 0; i < 40 && mem_we === 1'b1; i++) begin
      we_cycles++;
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (we_cycles !== 16) begin
      n_fail++;
      $display("FAIL timeout_len: mem_we cycles %0d want 16", we_cycles);
    end
    n_checks++;
    if (err !== 1'b1 || done !== 1'b0 || saw_done) begin
      n_fail++;
      $display("FAIL timeout_err: err %b done %b saw_done %b want 1/0/0", err, done, saw_done);
    end
    @(negedge clk);
    n_checks++;
    if ({st_ready, busy, mem_we, done, err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL timeout_idle: got %b want 10000", {st_ready, busy, mem_we, done, err});
    end
  endtask

  task automatic test_range;
    do_accept(20'h10000, 20'h22222);
    n_checks++;
    if ({st_ready, busy, mem_we, done, err} !== 5'b01001 || mem_addr !== 20'h0) begin
      n_fail++;
      $display("FAIL range_err: ctrl %b addr %h want 01001/0",
               {st_ready, busy, mem_we, done, err}, mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({st_ready, busy, mem_we, done, err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL range_idle: got %b want 10000", {st_ready, busy, mem_we, done, err});
    end
    // highest legal address is accepted for writing
    do_accept(20'h0FFFF, 20'h33333);
    n_checks++;
    if (mem_we !== 1'b1 || err !== 1'b0 || mem_addr !== 20'h0FFFF) begin
      n_fail++;
      $display("FAIL range_top: we %b err %b addr %h want 1/0/0ffff", mem_we, err, mem_addr);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL range_top_done: done %b err %b want 1/0", done, err);
    end
    @(negedge clk);
  endtask

  task automatic test_ack_at_timeout;
    do_accept(20'h00024, 20'h44444);
    for (int i = 1; i < 16; i++) @(negedge clk);
    // 16th WRITE cycle: counter sits at TIMEOUT
    n_checks++;
    if (mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL race_we: we %b want 1 in 16th write cycle", mem_we);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL race_done: done %b err %b we %b want 1/0/0", done, err, mem_we);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_write;
    bit stray;
    stray = 1'b0;
    do_accept(20'h00030, 20'h55555);
    @(negedge clk);
    @(negedge clk);
    // third WRITE cycle
    n_checks++;
    if (mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL rstw_pre: we %b want 1", mem_we);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({st_ready, busy, mem_we, done, err} !== 5'b10000 ||
        {mem_addr, mem_wdata} !== 40'h0) begin
      n_fail++;
      $display("FAIL rstw_async: ctrl %b addr %h data %h want 10000/0/0",
               {st_ready, busy, mem_we, done, err}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (done !== 1'b0 || err !== 1'b0 || mem_we !== 1'b0) stray = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (stray) begin
      n_fail++;
      $display("FAIL rstw_stray: done/err/we seen after reset, want none");
    end
    // first request after reset is accepted and completes
    do_accept(20'h00050, 20'h0AAAA);
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 20'h00050 || mem_wdata !== 20'h0AAAA) begin
      n_fail++;
      $display("FAIL rstw_next_w: we %b addr %h data %h want 1/00050/0aaaa",
               mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_next_done: done %b err %b want 1/0", done, err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    st_valid = 1'b1;
    Ro = 20'h00060;
    Rs = 20'h12345;
    @(negedge clk);
    // first store in WRITE; inputs change but must not matter
    Ro = 20'h00070;
    Rs = 20'h54321;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 20'h00060 || mem_wdata !== 20'h12345) begin
      n_fail++;
      $display("FAIL b2b_w1: we %b addr %h data %h want 1/00060/12345",
               mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (done !== 1'b1 || st_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done1: done %b ready %b want 1/0", done, st_ready);
    end
    @(negedge clk);
    n_checks++;
    if (st_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: ready %b we %b want 1/0", st_ready, mem_we);
    end
    @(negedge clk);
    st_valid = 1'b0;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 20'h00070 || mem_wdata !== 20'h54321) begin
      n_fail++;
      $display("FAIL b2b_w2: we %b addr %h data %h want 1/00070/54321",
               mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done2: done %b err %b want 1/0", done, err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_store();
    test_ack_ignored_idle();
    test_timeout();
    test_range();
    test_ack_at_timeout();
    test_reset_in_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_direct.md
STORE_DIRECT -- requirements
Module: store_direct

Interface
REQ-001 Parameter AW, default 20, address width.
REQ-002 Parameter DW, default 20, data width.
REQ-003 Parameter MEM_TOP, default 20'hFFFFF, highest legal store address.
REQ-004 Parameter TIMEOUT, default 15, maximum wait cycles for mem_ack (legal range 1..255).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 st_valid  input  1  store request valid.
REQ-008 st_ready  output  1  block can accept a request.
REQ-009 Ro  input  AW  destination memory address of the store.
REQ-010 Rs  input  DW  source register value to be stored.
REQ-011 mem_addr  output  AW  memory write address.
REQ-012 mem_wdata  output  DW  memory write data.
REQ-013 mem_we  output  1  memory write strobe.
REQ-014 mem_ack  input  1  memory write acknowledge.
REQ-015 done  output  1  one-cycle pulse: store completed.
REQ-016 err  output  1  one-cycle pulse: store rejected or timed out.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The block SHALL implement the states IDLE, WRITE, DONE and ERR.
REQ-019 st_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge where st_valid=1 and st_ready=1.
REQ-020 On accept, the block SHALL latch Ro and Rs into internal registers; later changes to Ro and Rs SHALL have no effect until the next accept.
REQ-021 Accept with latched Ro <= MEM_TOP: the next state SHALL be WRITE, with the wait counter cleared to 0.
REQ-022 Accept with Ro > MEM_TOP: the next state SHALL be ERR; mem_we SHALL never assert for that request.
REQ-023 In WRITE: mem_we=1, mem_addr and mem_wdata SHALL equal the latched values, held stable until WRITE exits.
REQ-024 In WRITE with mem_ack=1 sampled: the next state SHALL be DONE.
REQ-025 In WRITE with mem_ack=0: the counter SHALL increment; when it equals TIMEOUT, the next state SHALL be ERR.
REQ-026 mem_ack=1 in the same cycle the counter reaches TIMEOUT: ack SHALL win and the next state SHALL be DONE.
REQ-027 In DONE: done=1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-028 In ERR: err=1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-029 Minimum latency SHALL be: accept edge -> mem_we high the next cycle -> done high 1 cycle after the ack edge; back-to-back stores SHALL take 3 cycles each at best.
REQ-030 mem_ack outside WRITE SHALL be ignored.
REQ-031 mem_we SHALL be 0 in IDLE, DONE and ERR.
REQ-032 done and err SHALL never be high in the same cycle.
REQ-033 mem_addr and mem_wdata SHALL be 0 whenever mem_we=0.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE, counter 0, latched address and data 0, and outputs st_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, busy=0, without waiting for a clock edge.
REQ-035 Reset during WRITE SHALL drop mem_we asynchronously; the aborted store SHALL produce neither done nor err.
REQ-036 After rst_n deasserts, the first request SHALL be accepted on the first rising edge where st_valid=1.

Verification
REQ-037 Ro=20'h00010, Rs=20'hABCDE, mem_ack high 2 cycles after mem_we -> mem_we held 2 cycles with addr 00010 / data ABCDE, then done pulse 1 cycle, busy falls, st_ready=1.
REQ-038 Ro=20'h00020, mem_ack held 0, TIMEOUT=15 -> mem_we high exactly 16 cycles, then err pulse, no done.
REQ-039 MEM_TOP=20'h0FFFF, Ro=20'h10000 -> err pulse 1 cycle after accept, mem_we never asserts.
REQ-040 mem_ack=1 on the cycle the counter reaches TIMEOUT -> done pulse, no err.
REQ-041 rst_n pulled low during the 3rd WRITE cycle -> mem_we=0 immediately, all outputs at reset values, no done or err; the next request completes normally.
REQ-042 Ro and Rs changed while busy, and st_valid held high continuously -> the memory write uses the originally latched values; a second request is accepted only in the cycle after done.
